// File: rtl/pkt_frame_checker.sv
// pkt_frame_checker
//   Framing sanitizer for a valid/ready packet stream (sop/eop delimited).
//   Every packet it emits starts with sop and ends with eop, and no packet
//   is longer than MAX_BEATS beats. Orphan beats and beats following a cut
//   or truncated packet are accepted and discarded. Each framing error is
//   flagged with a one-cycle pulse. The output is a single register stage.
//
//   Optional macro PKT_FRAME_CHECKER_STATS_EN: when defined, the packet and
//   drop counters are built; otherwise both stat ports are tied to zero.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         upstream handshake
//   in_data/in_sop/in_eop     upstream beat (sop/eop sampled on accept)
//   out_valid/out_ready       downstream handshake (out_* registered)
//   out_data/out_sop/out_eop  downstream beat
//   err_orphan                beat outside any packet discarded
//   err_trunc                 sop arrived inside an open packet
//   err_oversize              packet cut at MAX_BEATS
//   stat_pkt_cnt              packets emitted with eop
//   stat_drop_cnt             beats discarded
module pkt_frame_checker #(
  parameter int DATA_WIDTH = 20,
  parameter int MAX_BEATS  = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sop,
  input  logic                  in_eop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic                  err_orphan,
  output logic                  err_trunc,
  output logic                  err_oversize,
  output logic [CNT_WIDTH-1:0]  stat_pkt_cnt,
  output logic [CNT_WIDTH-1:0]  stat_drop_cnt
);

  localparam int BCW = $clog2(MAX_BEATS + 1);
  localparam logic [BCW-1:0] LAST_CNT = BCW'(MAX_BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t          state;
  logic [BCW-1:0]  beat_cnt;

  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic                  sop_p1;
  logic                  eop_p1;
  logic                  orphan_p1;
  logic                  trunc_p1;
  logic                  over_p1;

  logic                  accept;
  logic                  fwd;
  logic                  fwd_sop;
  logic                  fwd_eop;
  logic                  orphan;
  logic                  trunc;
  logic                  over;
  state_t                nxt_state;
  logic [BCW-1:0]        nxt_cnt;

  // Ready depends only on the output register, never on framing state, so a
  // discarded beat drains at the same rate as a forwarded one.
  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready;

  // p0: classify the incoming beat against the current framing state
  always_comb begin
    fwd       = 1'b0;
    fwd_sop   = 1'b0;
    fwd_eop   = 1'b0;
    orphan    = 1'b0;
    trunc     = 1'b0;
    over      = 1'b0;
    nxt_state = state;
    nxt_cnt   = beat_cnt;
    case (state)
      IDLE: begin
        if (in_sop) begin
          fwd     = 1'b1;
          fwd_sop = 1'b1;
          fwd_eop = in_eop;
          if (!in_eop) begin
            nxt_state = PKT;
            nxt_cnt   = BCW'(1);
          end
        end else begin
          orphan    = 1'b1;
          nxt_state = in_eop ? IDLE : DROP;
        end
      end
      PKT: begin
        fwd = 1'b1;
        if (in_sop) begin
          // A new sop closes the open packet with this beat; the rest of the
          // new packet has lost its start and is discarded.
          fwd_eop   = 1'b1;
          trunc     = 1'b1;
          nxt_state = in_eop ? IDLE : DROP;
          nxt_cnt   = '0;
        end else if (in_eop) begin
          fwd_eop   = 1'b1;
          nxt_state = IDLE;
          nxt_cnt   = '0;
        end else if (beat_cnt == LAST_CNT) begin
          fwd_eop   = 1'b1;
          over      = 1'b1;
          nxt_state = DROP;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = beat_cnt + 1'b1;
        end
      end
      DROP: begin
        if (in_eop) nxt_state = IDLE;
      end
      default: begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
      end
    endcase
  end

  // p1: registered output beat and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      vld_p1    <= 1'b0;
      data_p1   <= '0;
      sop_p1    <= 1'b0;
      eop_p1    <= 1'b0;
      orphan_p1 <= 1'b0;
      trunc_p1  <= 1'b0;
      over_p1   <= 1'b0;
    end else begin
      orphan_p1 <= accept && orphan;
      trunc_p1  <= accept && trunc;
      over_p1   <= accept && over;
      if (accept) begin
        state    <= nxt_state;
        beat_cnt <= nxt_cnt;
      end
      // A discarded accept can only happen when the register is empty or
      // draining, so clearing on out_ready covers that case as well.
      if (accept && fwd) begin
        vld_p1  <= 1'b1;
        data_p1 <= in_data;
        sop_p1  <= fwd_sop;
        eop_p1  <= fwd_eop;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid    = vld_p1;
  assign out_data     = data_p1;
  assign out_sop      = sop_p1;
  assign out_eop      = eop_p1;
  assign err_orphan   = orphan_p1;
  assign err_trunc    = trunc_p1;
  assign err_oversize = over_p1;

`ifdef PKT_FRAME_CHECKER_STATS_EN
  logic [CNT_WIDTH-1:0] pkt_cnt;
  logic [CNT_WIDTH-1:0] drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (accept && fwd && fwd_eop) pkt_cnt <= pkt_cnt + 1'b1;
      if (accept && !fwd)           drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign stat_pkt_cnt  = pkt_cnt;
  assign stat_drop_cnt = drop_cnt;
`else
  assign stat_pkt_cnt  = '0;
  assign stat_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_pkt_frame_checker.sv
// tb_pkt_frame_checker
//   Directed scenarios followed by randomized traffic, checked every cycle
//   against a packet-level reference model (expected-beat queue plus
//   framing mode, error pulses and counters).
module tb_pkt_frame_checker;

  localparam int DW = 20;
  localparam int MB = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_sop;
  logic          in_eop;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_sop;
  logic          out_eop;
  logic          err_orphan;
  logic          err_trunc;
  logic          err_oversize;
  logic [CW-1:0] stat_pkt_cnt;
  logic [CW-1:0] stat_drop_cnt;

  pkt_frame_checker #(.DATA_WIDTH(DW), .MAX_BEATS(MB), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sop(out_sop), .out_eop(out_eop),
    .err_orphan(err_orphan), .err_trunc(err_trunc), .err_oversize(err_oversize),
    .stat_pkt_cnt(stat_pkt_cnt), .stat_drop_cnt(stat_drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          s;
    logic          e;
  } beat_t;

  // Reference model: queue of beats the downstream should see, framing mode
  // (0 = between packets, 1 = inside a packet, 2 = discarding), beats
  // forwarded in the open packet, expected pulses and counters.
  beat_t         exp_q[$];
  int            mode;
  int            len;
  logic          x_orphan, x_trunc, x_over;
  logic [CW-1:0] n_pkt, n_drop;
  bit            clean;
  bit            last_acc;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [DW-1:0] d, input logic s, input logic e);
    beat_t b;
    b.d = d; b.s = s; b.e = e;
    exp_q.push_back(b);
    clean = 1'b0;
    if (e) n_pkt++;
  endtask

  task automatic model_step(input bit acc);
    x_orphan = 1'b0; x_trunc = 1'b0; x_over = 1'b0;
    if (rst) begin
      exp_q.delete();
      mode = 0; len = 0; n_pkt = '0; n_drop = '0; clean = 1'b1;
    end else begin
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (acc) begin
        if (mode == 0) begin
          if (in_sop) begin
            push(in_data, 1'b1, in_eop);
            if (!in_eop) begin mode = 1; len = 1; end
          end else begin
            x_orphan = 1'b1; n_drop++;
            mode = in_eop ? 0 : 2;
          end
        end else if (mode == 1) begin
          if (in_sop) begin
            push(in_data, 1'b0, 1'b1); x_trunc = 1'b1;
            mode = in_eop ? 0 : 2;
          end else if (in_eop) begin
            push(in_data, 1'b0, 1'b1); mode = 0;
          end else if (len + 1 == MB) begin
            push(in_data, 1'b0, 1'b1); x_over = 1'b1; mode = 2;
          end else begin
            push(in_data, 1'b0, 1'b0); len++;
          end
        end else begin
          n_drop++;
          if (in_eop) mode = 0;
        end
      end
    end
  endtask

  task automatic compare_outputs();
    chk("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("out_data", out_data, exp_q[0].d);
      chk("out_sop", out_sop, exp_q[0].s);
      chk("out_eop", out_eop, exp_q[0].e);
    end else if (clean) begin
      chk("out_data_rst", out_data, 0);
      chk("out_sop_rst", out_sop, 0);
      chk("out_eop_rst", out_eop, 0);
    end
    chk("err_orphan", err_orphan, x_orphan);
    chk("err_trunc", err_trunc, x_trunc);
    chk("err_oversize", err_oversize, x_over);
`ifdef PKT_FRAME_CHECKER_STATS_EN
    chk("stat_pkt_cnt", stat_pkt_cnt, n_pkt);
    chk("stat_drop_cnt", stat_drop_cnt, n_drop);
`else
    chk("stat_pkt_cnt", stat_pkt_cnt, 0);
    chk("stat_drop_cnt", stat_drop_cnt, 0);
`endif
  endtask

  // One clock: inputs are already driven; check ready, step the model at the
  // edge, then compare outputs 1 time unit later.
  task automatic cycle();
    logic exp_rdy;
    #1;
    exp_rdy = (exp_q.size() == 0) || out_ready;
    chk("in_ready", in_ready, exp_rdy);
    last_acc = in_valid && exp_rdy && !rst;
    @(posedge clk);
    model_step(last_acc);
    #1;
    compare_outputs();
  endtask

  task automatic send(input logic [DW-1:0] d, input logic s, input logic e);
    int waited = 0;
    in_valid = 1'b1; in_data = d; in_sop = s; in_eop = e;
    do begin
      cycle();
      waited++;
    end while (!last_acc && waited < 50);
    if (!last_acc) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0;
    out_ready = 1'b1;
    mode = 0; len = 0; n_pkt = '0; n_drop = '0; clean = 1'b1;
    x_orphan = 1'b0; x_trunc = 1'b0; x_over = 1'b0; last_acc = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(1);

    // 3-beat packet
    send(20'h1, 1, 0); send(20'h2, 0, 0); send(20'h3, 0, 1); idle(2);
    // orphan beat, orphan eop beat, then a legal single-beat packet
    send(20'hA, 0, 0); send(20'hB, 0, 1); send(20'hC, 1, 1); idle(2);
    // 6-beat packet against MAX_BEATS=4
    send(20'h11, 1, 0);
    for (int i = 2; i <= 5; i++) send(DW'(20'h10 + i), 0, 0);
    send(20'h16, 0, 1); idle(2);
    // sop inside an open packet, then an eop beat
    send(20'h21, 1, 0); send(20'h22, 0, 0); send(20'h23, 1, 0); send(20'h24, 0, 1);
    idle(2);
    // 4-beat packet with a 5-cycle downstream stall
    send(20'h31, 1, 0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 20'h32; in_sop = 1'b0; in_eop = 1'b0;
    for (int i = 0; i < 5; i++) cycle();
    out_ready = 1'b1;
    send(20'h32, 0, 0); send(20'h33, 0, 0); send(20'h34, 0, 1); idle(2);
    // reset inside an open packet, then a beat without sop
    send(20'h41, 1, 0); send(20'h42, 0, 0);
    rst = 1'b1; idle(1); rst = 1'b0;
    send(20'h43, 0, 1); idle(2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = DW'($urandom);
      in_sop    = ($urandom_range(0, 3) == 0);
      in_eop    = ($urandom_range(0, 9) < 3);
      out_ready = ($urandom_range(0, 9) < 7);
      rst       = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0; out_ready = 1'b1;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pkt_frame_checker.md
Name: pkt_frame_checker

Overview:
- Stream-framing sanitizer placed directly downstream of the packet-mode dual-clock FIFO wrapper (MLAB infill path).
- Consumes the FIFO's valid/ready/data/sop/eop stream and guarantees legal framing to the next stage:
  - every emitted packet starts with sop and ends with eop;
  - no packet exceeds MAX_BEATS beats;
  - orphan and malformed beats are discarded and flagged.
- One registered output stage; flagged events are counted for CSR readout.

Parameters:
- DATA_WIDTH, 20, beat payload width (symbol width × symbols per beat).
- MAX_BEATS, 64, maximum legal packet length in beats; must be ≥ 2.
- CNT_WIDTH, 32, width of statistics counters.

Ports:
- clk  in  1  single clock domain.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  upstream beat accepted when in_valid && in_ready.
- in_data  in  DATA_WIDTH  upstream beat payload.
- in_sop  in  1  start of packet; sampled only on accept.
- in_eop  in  1  end of packet; sampled only on accept.
- out_valid  out  1  output beat valid (registered).
- out_ready  in  1  downstream ready.
- out_data  out  DATA_WIDTH  output payload (registered).
- out_sop  out  1  output start of packet (registered).
- out_eop  out  1  output end of packet (registered).
- err_orphan  out  1  one-cycle pulse: beat outside any packet discarded.
- err_trunc  out  1  one-cycle pulse: sop seen inside an open packet.
- err_oversize  out  1  one-cycle pulse: packet cut at MAX_BEATS.
- stat_pkt_cnt  out  CNT_WIDTH  packets emitted with eop.
- stat_drop_cnt  out  CNT_WIDTH  beats discarded.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, beat_cnt=0;
  - out_valid/out_sop/out_eop/err_* = 0; out_data = 0; counters = 0.
  - An in-flight output beat is lost.
  - Reset mid-packet: the first accepted beat after reset must carry sop, otherwise it is an orphan.
- Handshake:
  - in_ready = !out_valid || out_ready, combinational, same in every state.
  - Accept = in_valid && in_ready.
  - A forwarded beat appears on out_* the cycle after accept (latency 1).
  - The output register holds its contents while out_valid && !out_ready.
  - A dropped beat is still accepted but does not load out_valid. If out_ready=1 that cycle, out_valid clears.
- beat_cnt width is $clog2(MAX_BEATS+1). It counts forwarded beats of the open packet.
- State machine (transitions on accept only):
  - IDLE, sop && eop: forward, stay IDLE.
  - IDLE, sop && !eop: forward, beat_cnt=1, go PKT.
  - IDLE, !sop: discard, err_orphan; stay IDLE if eop, else go DROP.
  - PKT, sop: forward with out_sop=0, out_eop=1 (closes the current packet), err_trunc; go IDLE if in_eop, else DROP.
  - PKT, !sop && eop: forward, go IDLE.
  - PKT, !sop && !eop && beat_cnt==MAX_BEATS-1: forward with out_eop forced 1, err_oversize, go DROP.
  - PKT, other: forward, beat_cnt+1.
  - DROP: discard every beat. On eop go IDLE.
  - DROP, sop && !eop: counts as discard; no restart.
- A packet of exactly MAX_BEATS beats with eop on the last beat is legal.
- err_* are registered. Each pulses for exactly one cycle, the cycle after the triggering accept.
- Counters:
  - stat_pkt_cnt increments on every accept that loads out_eop=1 (normal or forced).
  - stat_drop_cnt increments on every discarded accept.
  - Both wrap modulo 2^CNT_WIDTH.

Optional Feature:
- Macro: PKT_FRAME_CHECKER_STATS_EN.
- Defined: stat_pkt_cnt and stat_drop_cnt are implemented as specified.
- Undefined: counter registers are not built; both stat ports are tied to 0. err_* pulses and framing behaviour are unchanged.

Test Plan:
- 3-beat packet (sop, -, eop), data 0x1,0x2,0x3, out_ready=1:
  - out_* shows the same beats one cycle later with sop on 0x1 and eop on 0x3;
  - stat_pkt_cnt=1, no err pulses.
- Beat 0xA with no sop/eop in IDLE, then beat 0xB with eop:
  - nothing emitted; err_orphan pulses once;
  - stat_drop_cnt=2; next sop&eop beat 0xC is forwarded.
- MAX_BEATS=4, 6-beat packet:
  - beats 1–4 forwarded, beat 4 with out_eop=1; err_oversize pulses once;
  - beats 5–6 dropped, stat_drop_cnt=2, stat_pkt_cnt=1.
- Sop on beat 3 of an open packet (in_eop=0), followed by a beat with eop:
  - beat 3 emitted with out_sop=0, out_eop=1; err_trunc pulses;
  - the following eop beat is dropped.
- out_ready held 0 for 5 cycles during a 4-beat packet:
  - in_ready=0 while the output is full;
  - output data is stable for the whole stall; no beat lost or duplicated after release.
- rst asserted after beat 2 of an open packet, then a beat without sop:
  - all outputs are 0 the cycle after rst;
  - the post-reset beat is treated as an orphan.
